// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-compatible PIC acknowledge path.
package pic_pkg;

   localparam int PIC_IR_W = 3;
   localparam int PIC_IR_N = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_ACK1 = 3'd2,
      ST_GAP  = 3'd3,
      ST_ACK2 = 3'd4,
      ST_DONE = 3'd5
   } pic_inta_state_t;

   function automatic logic [PIC_IR_N-1:0] pic_onehot(input logic [PIC_IR_W-1:0] idx);
      return 8'd1 << idx;
   endfunction

   // Isolates the lowest set bit, which is the highest-priority in-service level.
   function automatic logic [PIC_IR_N-1:0] pic_lowest_set(input logic [PIC_IR_N-1:0] v);
      return v & (~v + 8'd1);
   endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Fixed-priority resolver: lowest eligible IR wins; any in-service bit at or
// below an index blocks that index.
module pic_priority_resolver
   import pic_pkg::*;
(
   input  logic [PIC_IR_N-1:0] irr_priority,
   input  logic [PIC_IR_N-1:0] imr,
   input  logic [PIC_IR_N-1:0] isr,
   output logic                valid,
   output logic [PIC_IR_W-1:0] index
);

   logic blocked_s;

   // Scan from IR0 upward, accumulating the in-service block as we go.
   always_comb begin
      valid     = 1'b0;
      index     = 3'd0;
      blocked_s = 1'b0;
      for (int n = 0; n < PIC_IR_N; n++) begin
         blocked_s = blocked_s | isr[n];
         if (!valid && irr_priority[n] && !imr[n] && !blocked_s) begin
            valid = 1'b1;
            index = PIC_IR_W'(n);
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8086-mode interrupt-acknowledge sequencer with ISR/EOI ownership.
// Optional auto-EOI support is enabled by defining PIC_AEOI_EN.
module pic_inta_sequencer
   import pic_pkg::*;
#(
   parameter logic [PIC_IR_W-1:0] SPURIOUS_IR = 3'd7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PIC_IR_N-1:0] irr_priority,
   input  logic [PIC_IR_N-1:0] imr,
   input  logic [4:0]          vector_base,
   input  logic                inta_n,
   input  logic                eoi,
`ifdef PIC_AEOI_EN
   input  logic                aeoi,
`endif
   output logic                int_out,
   output logic                inta_freeze,
   output logic [PIC_IR_N-1:0] inta_1,
   output logic [PIC_IR_N-1:0] isr,
   output logic [PIC_IR_N-1:0] data_out,
   output logic                data_oe
);

   pic_inta_state_t      state_r;
   logic                 inta_prev_r;
   logic [PIC_IR_W-1:0]  latched_ir_r;
   logic                 spurious_r;

   logic                 elig_valid_s;
   logic [PIC_IR_W-1:0]  elig_idx_s;
   logic                 inta_fall_s;
   logic                 inta_rise_s;
   logic                 aeoi_s;
   logic [PIC_IR_N-1:0]  isr_set_s;
   logic [PIC_IR_N-1:0]  isr_clr_s;
   logic [PIC_IR_N-1:0]  isr_next_s;

`ifdef PIC_AEOI_EN
   assign aeoi_s = aeoi;
`else
   assign aeoi_s = 1'b0;
`endif

   assign inta_fall_s = inta_prev_r & ~inta_n;
   assign inta_rise_s = ~inta_prev_r & inta_n;

   pic_priority_resolver u_resolver (
      .irr_priority (irr_priority),
      .imr          (imr),
      .isr          (isr),
      .valid        (elig_valid_s),
      .index        (elig_idx_s)
   );

   // ISR update: clears act on the pre-set value, then the ACK1 grant is applied.
   always_comb begin
      isr_set_s = 8'd0;
      isr_clr_s = 8'd0;
      if (eoi) begin
         isr_clr_s = pic_lowest_set(isr);
      end else begin
         isr_clr_s = 8'd0;
      end
      if ((state_r == ST_DONE) && aeoi_s && !spurious_r) begin
         isr_clr_s = isr_clr_s | pic_onehot(latched_ir_r);
      end else begin
         isr_clr_s = isr_clr_s;
      end
      if ((state_r == ST_REQ) && inta_fall_s && elig_valid_s) begin
         isr_set_s = pic_onehot(elig_idx_s);
      end else begin
         isr_set_s = 8'd0;
      end
      isr_next_s = (isr & ~isr_clr_s) | isr_set_s;
   end

   // Handshake FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         inta_prev_r  <= 1'b1;
         latched_ir_r <= 3'd0;
         spurious_r   <= 1'b0;
         int_out      <= 1'b0;
         inta_freeze  <= 1'b0;
         inta_1       <= 8'd0;
         isr          <= 8'd0;
         data_out     <= 8'd0;
         data_oe      <= 1'b0;
      end else begin
         inta_prev_r <= inta_n;
         isr         <= isr_next_s;
         inta_1      <= 8'd0;
         case (state_r)
            ST_IDLE: begin
               if (elig_valid_s) begin
                  state_r <= ST_REQ;
                  int_out <= 1'b1;
               end
            end
            ST_REQ: begin
               if (inta_fall_s) begin
                  state_r     <= ST_ACK1;
                  int_out     <= 1'b0;
                  inta_freeze <= 1'b1;
                  if (elig_valid_s) begin
                     latched_ir_r <= elig_idx_s;
                     inta_1       <= pic_onehot(elig_idx_s);
                     spurious_r   <= 1'b0;
                  end else begin
                     latched_ir_r <= SPURIOUS_IR;
                     spurious_r   <= 1'b1;
                  end
               end else if (!elig_valid_s) begin
                  state_r <= ST_IDLE;
                  int_out <= 1'b0;
               end
            end
            ST_ACK1: begin
               state_r <= ST_GAP;
            end
            ST_GAP: begin
               // The fall detector already implies inta_n went high first.
               if (inta_fall_s) begin
                  state_r  <= ST_ACK2;
                  data_oe  <= 1'b1;
                  data_out <= {vector_base, latched_ir_r};
               end
            end
            ST_ACK2: begin
               if (inta_rise_s) begin
                  state_r <= ST_DONE;
                  data_oe <= 1'b0;
               end
            end
            ST_DONE: begin
               inta_freeze <= 1'b0;
               if (elig_valid_s) begin
                  state_r <= ST_REQ;
                  int_out <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               int_out     <= 1'b0;
               inta_freeze <= 1'b0;
               data_oe     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed scoreboard bench for pic_inta_sequencer.
module tb_pic_inta_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] irr_priority;
   logic [7:0] imr;
   logic [4:0] vector_base;
   logic       inta_n;
   logic       eoi;
`ifdef PIC_AEOI_EN
   logic       aeoi;
`endif
   logic       int_out;
   logic       inta_freeze;
   logic [7:0] inta_1;
   logic [7:0] isr;
   logic [7:0] data_out;
   logic       data_oe;

   typedef struct packed {
      logic [7:0] grant;
      logic [7:0] isr_ack;
      logic [7:0] vec;
      logic [7:0] isr_end;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pic_inta_sequencer #(.SPURIOUS_IR(3'd7)) dut (
      .clk          (clk),
      .reset        (reset),
      .irr_priority (irr_priority),
      .imr          (imr),
      .vector_base  (vector_base),
      .inta_n       (inta_n),
      .eoi          (eoi),
`ifdef PIC_AEOI_EN
      .aeoi         (aeoi),
`endif
      .int_out      (int_out),
      .inta_freeze  (inta_freeze),
      .inta_1       (inta_1),
      .isr          (isr),
      .data_out     (data_out),
      .data_oe      (data_oe)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic pulse_eoi();
      eoi = 1'b1;
      step();
      eoi = 1'b0;
   endtask

   // Runs both INTA pulses, comparing against the next scoreboard entry.
   task automatic handshake(input logic [7:0] irr_fall, input logic [7:0] irr_after);
      exp_t e;
      int   n;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = exp_q.pop_front();
         irr_priority = irr_fall;
         inta_n = 1'b0;
         step();
         check("ack1_inta_1", inta_1, e.grant);
         check("ack1_isr", isr, e.isr_ack);
         check("ack1_freeze", {7'd0, inta_freeze}, 8'd1);
         check("ack1_int_out", {7'd0, int_out}, 8'd0);
         irr_priority = irr_after;
         step();
         check("gap_inta_1", inta_1, 8'd0);
         inta_n = 1'b1;
         step();
         inta_n = 1'b0;
         step();
         n = 0;
         while (data_oe !== 1'b1 && n < 4) begin
            step();
            n++;
         end
         check("ack2_data_oe", {7'd0, data_oe}, 8'd1);
         check("ack2_data_out", data_out, e.vec);
         step();
         check("ack2_hold_oe", {7'd0, data_oe}, 8'd1);
         check("ack2_hold_data", data_out, e.vec);
         inta_n = 1'b1;
         step();
         check("done_data_oe", {7'd0, data_oe}, 8'd0);
         check("done_freeze", {7'd0, inta_freeze}, 8'd1);
         step();
         check("post_freeze", {7'd0, inta_freeze}, 8'd0);
         check("post_isr", isr, e.isr_end);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      irr_priority = 8'h00;
      imr = 8'h00;
      vector_base = 5'h10;
      inta_n = 1'b1;
      eoi = 1'b0;
`ifdef PIC_AEOI_EN
      aeoi = 1'b0;
`endif
      step();
      step();
      check("rst_int_out", {7'd0, int_out}, 8'd0);
      check("rst_freeze", {7'd0, inta_freeze}, 8'd0);
      check("rst_inta_1", inta_1, 8'd0);
      check("rst_isr", isr, 8'd0);
      check("rst_data_out", data_out, 8'd0);
      check("rst_data_oe", {7'd0, data_oe}, 8'd0);
      reset = 1'b0;

      // IR3 basic acknowledge, vector {10h,3} = 83h
      irr_priority = 8'h08;
      step();
      check("ir3_int_out", {7'd0, int_out}, 8'd1);
      exp_q.push_back({8'h08, 8'h08, 8'h83, 8'h08});
      handshake(8'h08, 8'h00);
      pulse_eoi();
      check("ir3_eoi_isr", isr, 8'h00);

      // IR2 in service blocks IR2/IR3 until EOI
      irr_priority = 8'h04;
      step();
      check("ir2_int_out", {7'd0, int_out}, 8'd1);
      exp_q.push_back({8'h04, 8'h04, 8'h82, 8'h04});
      handshake(8'h04, 8'h0C);
      step();
      check("blocked_int_out", {7'd0, int_out}, 8'd0);
      step();
      check("blocked_int_out2", {7'd0, int_out}, 8'd0);
      pulse_eoi();
      check("unblock_isr", isr, 8'h00);
      step();
      check("unblock_int_out", {7'd0, int_out}, 8'd1);
      exp_q.push_back({8'h04, 8'h04, 8'h82, 8'h04});
      handshake(8'h0C, 8'h00);
      pulse_eoi();
      check("ir2_eoi_isr", isr, 8'h00);

      // IR5 withdrawn before INTA
      irr_priority = 8'h20;
      step();
      check("ir5_int_out", {7'd0, int_out}, 8'd1);
      irr_priority = 8'h00;
      step();
      check("ir5_withdraw", {7'd0, int_out}, 8'd0);
      step();
      check("ir5_idle", {7'd0, int_out}, 8'd0);

      // IR5 withdrawn at the first INTA fall: spurious IR7
      irr_priority = 8'h20;
      step();
      check("spur_int_out", {7'd0, int_out}, 8'd1);
      exp_q.push_back({8'h00, 8'h00, 8'h87, 8'h00});
      handshake(8'h00, 8'h00);

      // Fully masked requests never raise int_out
      imr = 8'hFF;
      irr_priority = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         step();
         check("masked_int_out", {7'd0, int_out}, 8'd0);
      end
      irr_priority = 8'h00;
      imr = 8'h00;

`ifdef PIC_AEOI_EN
      // Auto-EOI clears IR1 at the end of the handshake
      aeoi = 1'b1;
      irr_priority = 8'h02;
      step();
      check("aeoi_int_out", {7'd0, int_out}, 8'd1);
      exp_q.push_back({8'h02, 8'h02, 8'h81, 8'h00});
      handshake(8'h02, 8'h00);
      aeoi = 1'b0;
`endif

      // Reset during GAP aborts; later INTA pulses are ignored
      irr_priority = 8'h01;
      step();
      check("gap_int_out", {7'd0, int_out}, 8'd1);
      inta_n = 1'b0;
      step();
      check("gap_ack1_inta_1", inta_1, 8'h01);
      step();
      check("gap_freeze", {7'd0, inta_freeze}, 8'd1);
      reset = 1'b1;
      irr_priority = 8'h00;
      step();
      check("abort_isr", isr, 8'h00);
      check("abort_freeze", {7'd0, inta_freeze}, 8'd0);
      check("abort_int_out", {7'd0, int_out}, 8'd0);
      check("abort_data_oe", {7'd0, data_oe}, 8'd0);
      reset = 1'b0;
      inta_n = 1'b1;
      step();
      inta_n = 1'b0;
      step();
      step();
      check("ignored_data_oe", {7'd0, data_oe}, 8'd0);
      check("ignored_inta_1", inta_1, 8'h00);
      check("ignored_freeze", {7'd0, inta_freeze}, 8'd0);
      inta_n = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pic_inta_sequencer.md
# pic_inta_sequencer

Interrupt-acknowledge sequencer for the 8259A-compatible PIC. It takes pending requests from the interrupt request register, resolves priority against the mask and in-service state, and raises INT to the CPU. It then services the two-pulse INTA handshake (8086 mode) and returns the vector byte. It drives the freeze and clear-bit signals back into the request register, and owns the in-service register (ISR) and EOI handling.

## Interface
Parameters:
- SPURIOUS_IR, 3'd7: IR level whose vector is returned on a spurious acknowledge.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- irr_priority  in  8  pending requests from the request register, bit n = IRn
- imr  in  8  interrupt mask, 1 = masked
- vector_base  in  5  ICW2 T7–T3
- inta_n  in  1  CPU acknowledge strobe, active low, synchronous to clk
- eoi  in  1  one-cycle non-specific EOI pulse from command decode
- aeoi  in  1  auto-EOI mode from ICW4 (present only with PIC_AEOI_EN)
- int_out  out  1  interrupt request to CPU
- inta_freeze  out  1  freezes the request register during acknowledge
- inta_1  out  8  one-hot, one-cycle clear strobe for the granted IR bit
- isr  out  8  in-service register
- data_out  out  8  vector byte
- data_oe  out  1  data bus drive enable

## Operation
- Eligibility: bit n is eligible when irr_priority[n] & ~imr[n], and no isr bit at index ≤ n is set. Priority is fixed; IR0 is highest. The winner is the lowest eligible index.
- FSM states: IDLE, REQ, ACK1, GAP, ACK2, DONE.
  - IDLE → REQ: any eligible bit exists. int_out = 1 in REQ.
  - REQ → IDLE: the eligible set becomes empty before an INTA fall. int_out drops.
  - REQ → ACK1: falling edge of inta_n, i.e. the registered previous value was 1 and the current value is 0.
  - ACK1 (one cycle): latch the winner, set the isr bit, pulse inta_1 with its one-hot value, assert inta_freeze, deassert int_out.
    - Spurious case: if no bit is eligible in this cycle, latch SPURIOUS_IR, leave isr and inta_1 at zero, and flag the request as spurious.
  - ACK1 → GAP. GAP waits for inta_n high, then for the next falling edge → ACK2.
  - ACK2: data_out = {vector_base, latched_ir}. data_oe stays 1 while inta_n = 0.
  - ACK2 → DONE on the inta_n rising edge. DONE (one cycle): data_oe = 0, inta_freeze = 0. If aeoi is set and the request was not spurious, clear the latched isr bit. DONE → IDLE.
- EOI: when eoi = 1, clear the lowest-index set isr bit; if isr is zero, do nothing. If eoi coincides with an ACK1 set, the clear uses the pre-set isr, then the set is applied.
- If int_out drops while in GAP or ACK2, the handshake is still completed.

## Timing
- Reset values: int_out = 0, inta_freeze = 0, inta_1 = 0, isr = 0, data_out = 0, data_oe = 0, state = IDLE. A reset mid-handshake aborts immediately to these values.
- int_out rises 1 cycle after the eligible bit appears at the inputs, because it is registered.
- An inta_n fall is detected in the cycle after the sample. ACK1 outputs are registered and valid one cycle after detection.
- inta_1 is exactly one cycle wide. inta_freeze is held from ACK1 through DONE inclusive.
- data_out is valid in the same cycle data_oe rises, and is held stable until data_oe falls.
- Back-to-back: a new REQ can assert in the cycle after DONE.

## Configuration
- PIC_AEOI_EN defined: the aeoi port exists, and auto-EOI clears the ISR bit in DONE.
- PIC_AEOI_EN undefined: the aeoi port is absent, and the ISR bit is cleared only by eoi.

## Structure
- Shared package pic_pkg holds:
  - the FSM state enum pic_inta_state_t;
  - the IR index width constant PIC_IR_W = 3;
  - the one-hot decode helper function.
- One sub-module, pic_priority_resolver: combinational lowest-index select over the masked, ISR-blocked requests. It outputs a valid bit and a 3-bit index.

## Test plan
- irr_priority = 8'h08, imr = 0, vector_base = 5'h10, two INTA pulses → int_out = 1; inta_1 = 8'h08 for 1 cycle; isr = 8'h08; data_out = 8'h83 during the second pulse.
- irr_priority = 8'h0C with isr = 8'h04 in service → no int_out. After eoi, isr = 0, int_out = 1, and the granted IR is 2.
- Request on IR5 removed after int_out rises but before the first INTA → state IDLE, int_out = 0. Removed after the first INTA fall instead → isr unchanged, inta_1 = 0, data_out = {vector_base, 3'd7}.
- imr = 8'hFF with irr_priority = 8'hFF → int_out stays 0 indefinitely.
- With PIC_AEOI_EN and aeoi = 1, IR1 acknowledged → isr = 8'h02 after ACK1, returns to 0 in DONE.
- reset asserted during GAP → all outputs 0 next cycle, and the next INTA pulses are ignored.
